pio_read_arbiter: RTL and testbench

Shares one fixed-latency, read-only Avalon-MM PIO slave (the 32-bit version/status input ports in soc_system) between several read masters, e.g. the HPS lightweight bridge and the FPGA-side DAQ sequencer. It grants at most one read per cycle using round-robin arbitration. It issues the winner's address to the slave and routes the slave's registered readdata back to the correct master, with a per-master readdatavalid after the slave's fixed read latency. Reads are fully pipelined, so a new read can issue every cycle.

---
 rtl/pio_read_arbiter_pkg.sv | 20 ++
 rtl/pio_read_arbiter_rr_arbiter.sv | 51 +++++
 rtl/pio_read_arbiter.sv | 85 ++++++++
 tb/tb_pio_read_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_read_arbiter_pkg.sv
// rtl/pio_read_arbiter_pkg.sv - shared types and helpers for the PIO read arbiter
package pio_read_arbiter_pkg;

   localparam int MAX_MASTERS = 8;
   localparam int IDX_W_MAX   = 3;

   // Index width for n masters, never below one bit.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [IDX_W_MAX-1:0] idx;
   } rd_entry_t;

endpackage

// File: rtl/pio_read_arbiter_rr_arbiter.sv
// rtl/pio_read_arbiter_rr_arbiter.sv - round-robin arbiter with internal last-grant pointer
module rr_arbiter
   import pio_read_arbiter_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_grant,
   output logic          o_grant_any,
   output logic [IW-1:0] o_grant_idx
);

   logic [IW-1:0] r_last;
   logic          w_any;
   logic [IW-1:0] w_idx;
   int            w_cand;

   // Search starts one past the last winner and wraps; no grant while in reset.
   always_comb begin
      w_any  = 1'b0;
      w_idx  = '0;
      w_cand = 0;
      for (int k = 1; k <= N; k++) begin
         w_cand = (int'(r_last) + k) % N;
         if (!w_any && reset_n && i_req[IW'(w_cand)]) begin
            w_any = 1'b1;
            w_idx = IW'(w_cand);
         end
      end
   end

   always_comb begin
      o_grant = '0;
      if (w_any) o_grant[w_idx] = 1'b1;
   end

   assign o_grant_any = w_any;
   assign o_grant_idx = w_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= IW'(N - 1);
      end else if (w_any) begin
         r_last <= w_idx;
      end
   end

endmodule

// File: rtl/pio_read_arbiter.sv
// rtl/pio_read_arbiter.sv - shares one fixed-latency read-only PIO slave between several masters
module pio_read_arbiter
   import pio_read_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS  = 2,
   parameter  int ADDR_W       = 2,
   parameter  int DATA_W       = 32,
   parameter  int READ_LATENCY = 1,
   localparam int IW           = idx_width(NUM_MASTERS)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_MASTERS-1:0]        i_m_read,
   input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_address,
   output logic [NUM_MASTERS-1:0]        o_m_waitrequest,
   output logic [DATA_W-1:0]             o_m_readdata,
   output logic [NUM_MASTERS-1:0]        o_m_readdatavalid,
   output logic [ADDR_W-1:0]             o_s_address,
   input  logic [DATA_W-1:0]             i_s_readdata
);

   logic [NUM_MASTERS-1:0] w_grant;
   logic                   w_grant_any;
   logic [IW-1:0]          w_grant_idx;
   logic [ADDR_W-1:0]      w_win_addr;
   logic [ADDR_W-1:0]      r_addr_hold;
   rd_entry_t              w_stage0;
   rd_entry_t              w_tail;
   rd_entry_t              r_pipe [READ_LATENCY];

   rr_arbiter #(
      .N (NUM_MASTERS)
   ) u_rr_arbiter (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_req       (i_m_read),
      .o_grant     (w_grant),
      .o_grant_any (w_grant_any),
      .o_grant_idx (w_grant_idx)
   );

   assign o_m_waitrequest = i_m_read & ~w_grant;

   always_comb begin
      w_win_addr = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_grant[i]) w_win_addr = i_m_address[i*ADDR_W +: ADDR_W];
      end
   end

   // The slave has no read strobe, so the address is held between grants.
   assign o_s_address = w_grant_any ? w_win_addr : r_addr_hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr_hold <= '0;
      end else if (w_grant_any) begin
         r_addr_hold <= w_win_addr;
      end
   end

   assign w_stage0.valid = w_grant_any;
   assign w_stage0.idx   = IDX_W_MAX'(w_grant_idx);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_stage0;
         for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign w_tail = r_pipe[READ_LATENCY-1];

   always_comb begin
      o_m_readdatavalid = '0;
      o_m_readdata      = '0;
      if (w_tail.valid) begin
         o_m_readdatavalid[IW'(w_tail.idx)] = 1'b1;
         o_m_readdata                       = i_s_readdata;
      end
   end

endmodule

// File: tb/tb_pio_read_arbiter.sv
// tb/tb_pio_read_arbiter.sv - directed self-checking bench for pio_read_arbiter
module tb_pio_read_arbiter;

   logic        clk;
   logic        ra_n, rb_n;
   logic [1:0]  a_read, a_wait, a_rdv, a_saddr;
   logic [3:0]  a_addr;
   logic [31:0] a_rdata, a_srd;
   logic [3:0]  b_read, b_wait, b_rdv;
   logic [7:0]  b_addr;
   logic [1:0]  b_saddr;
   logic [31:0] b_rdata, b_srd, b_d1, b_d2, b_d3;
   int          total, bad;
   logic [3:0]  b_wait_tab [8];

   pio_read_arbiter #(.NUM_MASTERS(2), .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1)) u_dut_a (
      .clk (clk), .reset_n (ra_n), .i_m_read (a_read), .i_m_address (a_addr),
      .o_m_waitrequest (a_wait), .o_m_readdata (a_rdata), .o_m_readdatavalid (a_rdv),
      .o_s_address (a_saddr), .i_s_readdata (a_srd)
   );

   pio_read_arbiter #(.NUM_MASTERS(4), .ADDR_W(2), .DATA_W(32), .READ_LATENCY(3)) u_dut_b (
      .clk (clk), .reset_n (rb_n), .i_m_read (b_read), .i_m_address (b_addr),
      .o_m_waitrequest (b_wait), .o_m_readdata (b_rdata), .o_m_readdatavalid (b_rdv),
      .o_s_address (b_saddr), .i_s_readdata (b_srd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave A: one registered stage; address 1 and 3 are undecoded.
   always @(posedge clk) begin
      case (a_saddr)
         2'd0:    a_srd <= 32'h2021_0517;
         2'd2:    a_srd <= 32'hA5A5_0002;
         default: a_srd <= 32'h0;
      endcase
   end

   // Slave B: three registered stages returning a tagged address.
   always @(posedge clk) begin
      b_d1 <= 32'hB000_0000 | 32'(b_saddr);
      b_d2 <= b_d1;
      b_d3 <= b_d2;
   end
   assign b_srd = b_d3;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      total = 0; bad = 0;
      b_wait_tab[0] = 4'b1110; b_wait_tab[1] = 4'b1100; b_wait_tab[2] = 4'b1000;
      b_wait_tab[3] = 4'b0000; b_wait_tab[4] = 4'b0000; b_wait_tab[5] = 4'b0000;
      b_wait_tab[6] = 4'b0000; b_wait_tab[7] = 4'b0000;
      ra_n = 1'b0; rb_n = 1'b0;
      a_read = 2'b11; a_addr = 4'b0; b_read = 4'b1111; b_addr = 8'b0;
      repeat (3) step();
      #1;
      check("rst_a_wait", 32'(a_wait), 32'h3);
      check("rst_a_rdv", 32'(a_rdv), 32'h0);
      check("rst_a_rdata", a_rdata, 32'h0);
      check("rst_a_saddr", 32'(a_saddr), 32'h0);
      check("rst_b_wait", 32'(b_wait), 32'hF);
      check("rst_b_rdv", 32'(b_rdv), 32'h0);

      // Single read by master 0 in the first cycle out of reset.
      step();
      ra_n = 1'b1; rb_n = 1'b1; b_read = 4'b0;
      a_read = 2'b01; a_addr = 4'b0000;
      #1;
      check("t1_wait", 32'(a_wait), 32'h0);
      check("t1_saddr", 32'(a_saddr), 32'h0);
      step();
      a_read = 2'b10; a_addr = 4'b1000;
      #1;
      check("t1_rdv", 32'(a_rdv), 32'h1);
      check("t1_rdata", a_rdata, 32'h2021_0517);

      // Master 1 alone for four back-to-back cycles.
      for (int c = 0; c < 4; c++) begin
         if (c > 0) #1;
         check("solo_wait", 32'(a_wait), 32'h0);
         check("solo_saddr", 32'(a_saddr), 32'h2);
         if (c > 0) begin
            check("solo_rdv", 32'(a_rdv), 32'h2);
            check("solo_rdata", a_rdata, 32'hA5A5_0002);
         end
         step();
      end

      // Both masters continuously: 0,1,0,1.
      a_read = 2'b11; a_addr = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("alt_wait", 32'(a_wait), (c % 2 == 0) ? 32'h2 : 32'h1);
         check("alt_saddr", 32'(a_saddr), (c % 2 == 0) ? 32'h0 : 32'h1);
         if (c == 0) begin
            check("alt_rdv", 32'(a_rdv), 32'h2);
            check("alt_rdata", a_rdata, 32'hA5A5_0002);
         end else if (c % 2 == 1) begin
            check("alt_rdv", 32'(a_rdv), 32'h1);
            check("alt_rdata", a_rdata, 32'h2021_0517);
         end else begin
            check("alt_rdv", 32'(a_rdv), 32'h2);
            check("alt_rdata", a_rdata, 32'h0);
         end
         step();
      end

      // Idle after master 1's read of address 1.
      a_read = 2'b00;
      #1;
      check("idle_rdv0", 32'(a_rdv), 32'h2);
      check("idle_saddr0", 32'(a_saddr), 32'h1);
      check("idle_wait", 32'(a_wait), 32'h0);
      step();
      #1;
      check("idle_rdv1", 32'(a_rdv), 32'h0);
      check("idle_rdata1", a_rdata, 32'h0);
      check("idle_saddr1", 32'(a_saddr), 32'h1);

      // Master 1 stalls, then drops its request and must not be served.
      step();
      a_read = 2'b11; a_addr = 4'b0010;
      #1;
      check("drop_wait", 32'(a_wait), 32'h2);
      step();
      a_read = 2'b00;
      #1;
      check("drop_rdv", 32'(a_rdv), 32'h1);
      check("drop_rdata", a_rdata, 32'hA5A5_0002);
      check("drop_saddr", 32'(a_saddr), 32'h2);
      step();
      #1;
      check("drop_norv", 32'(a_rdv), 32'h0);

      // Four masters, latency 3, all request together.
      step();
      b_read = 4'b1111; b_addr = 8'b1110_0100;
      for (int c = 0; c < 8; c++) begin
         #1;
         check("b_wait", 32'(b_wait), 32'(b_wait_tab[c]));
         check("b_saddr", 32'(b_saddr), (c < 4) ? 32'(c) : 32'h3);
         if (c >= 3 && c <= 6) begin
            check("b_rdv", 32'(b_rdv), 32'h1 << (c - 3));
            check("b_rdata", b_rdata, 32'hB000_0000 | 32'(c - 3));
         end else begin
            check("b_rdv", 32'(b_rdv), 32'h0);
            check("b_rdata", b_rdata, 32'h0);
         end
         step();
         if (c < 4) b_read = b_read & ~(4'b0001 << c);
      end

      // Reset one cycle after a grant discards the in-flight read.
      b_read = 4'b0001; b_addr = 8'b0000_0001;
      #1;
      check("brst_wait", 32'(b_wait), 32'h0);
      check("brst_saddr", 32'(b_saddr), 32'h1);
      step();
      b_read = 4'b0000; rb_n = 1'b0;
      #1;
      check("brst_rdv0", 32'(b_rdv), 32'h0);
      check("brst_saddr0", 32'(b_saddr), 32'h0);
      step();
      rb_n = 1'b1;
      #1;
      check("brst_rdv1", 32'(b_rdv), 32'h0);
      check("brst_saddr1", 32'(b_saddr), 32'h0);
      step();
      #1;
      check("brst_rdv2", 32'(b_rdv), 32'h0);
      b_read = 4'b0011; b_addr = 8'b0000_1110;
      #1;
      check("brst_first", 32'(b_wait), 32'h2);
      check("brst_fsaddr", 32'(b_saddr), 32'h2);
      step();
      b_read = 4'b0010;
      #1;
      check("brst_second", 32'(b_wait), 32'h0);
      check("brst_ssaddr", 32'(b_saddr), 32'h3);
      step();
      b_read = 4'b0000;
      #1;
      check("brst_gap", 32'(b_rdv), 32'h0);
      step();
      #1;
      check("brst_rv0", 32'(b_rdv), 32'h1);
      check("brst_rd0", b_rdata, 32'hB000_0002);
      step();
      #1;
      check("brst_rv1", 32'(b_rdv), 32'h2);
      check("brst_rd1", b_rdata, 32'hB000_0003);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
